// File: rtl/dmem_ctrl.sv
// Single-port data memory controller with configurable wait states, byte/halfword/word
// access, sign/zero extension on loads and alignment/range fault reporting.
module dmem_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned WAIT       = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [31:0] err_addr_o
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned HI       = DEPTH_LOG2 + 2;
  localparam logic [3:0]  CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAITING, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_we, lat_signed, lat_err;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr, lat_wdata;
  logic [31:0] mem [DEPTH];

  logic        accept, enter_done;
  logic        cur_we, cur_signed, cur_fault;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] rd_word, load_val;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign accept     = (state == IDLE) && req_i;
  assign enter_done = (accept && (WAIT == 0)) || ((state == WAITING) && (cnt == 4'd0));

  // With zero wait states the access enters DONE on the accept edge, before the
  // latches hold it, so the request fields come straight from the inputs while IDLE.
  assign cur_we     = (state == IDLE) ? we_i     : lat_we;
  assign cur_size   = (state == IDLE) ? size_i   : lat_size;
  assign cur_signed = (state == IDLE) ? signed_i : lat_signed;
  assign cur_addr   = (state == IDLE) ? addr_i   : lat_addr;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cur_fault = 1'b0;
    case (cur_size)
      2'b00:   cur_fault = 1'b0;
      2'b01:   cur_fault = cur_addr[0];
      2'b10:   cur_fault = |cur_addr[1:0];
      default: cur_fault = 1'b1;
    endcase
    if (cur_addr[31:HI] != BASE_ADDR[31:HI]) cur_fault = 1'b1;
  end

  assign rd_word = mem[cur_addr[HI-1:2]];
  assign rd_byte = rd_word[{cur_addr[1:0], 3'b000} +: 8];
  assign rd_half = rd_word[{cur_addr[1], 4'b0000} +: 16];

  always_comb begin
    load_val = rd_word;
    case (cur_size)
      2'b00:   load_val = {{24{cur_signed & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{cur_signed & rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_i) state_nxt = (WAIT > 0) ? WAITING : DONE;
      WAITING: if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_signed <= 1'b0;
      lat_err    <= 1'b0;
      lat_size   <= 2'b00;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      rdata_o    <= 32'd0;
      err_addr_o <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_we     <= we_i;
        lat_signed <= signed_i;
        lat_size   <= size_i;
        lat_addr   <= addr_i;
        lat_wdata  <= wdata_i;
        lat_err    <= cur_fault;
        cnt        <= CNT_INIT;
      end else if ((state == WAITING) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_done) begin
        if (cur_fault)    err_addr_o <= cur_addr;
        else if (!cur_we) rdata_o    <= load_val;
      end
    end
  end

  // NOTE: the memory array has no reset; contents survive reset and it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if ((state == DONE) && lat_we && !lat_err) begin
      case (lat_size)
        2'b00:   mem[lat_addr[HI-1:2]][{lat_addr[1:0], 3'b000} +: 8]  <= lat_wdata[7:0];
        2'b01:   mem[lat_addr[HI-1:2]][{lat_addr[1], 4'b0000} +: 16] <= lat_wdata[15:0];
        default: mem[lat_addr[HI-1:2]]                                <= lat_wdata;
      endcase
    end
  end

  assign ready_o = (state == DONE);
  assign err_o   = (state == DONE) && lat_err;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: three instances (WAIT = 0, 1, 3) share the request
// fields and have private req lines; expected responses are queued when a request is driven.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [3];
  logic        we, sgn;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata [3];
  logic [31:0] err_addr [3];
  logic        ready [3];
  logic        busy [3];
  logic        err [3];

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_LOG2(10), .WAIT(0), .BASE_ADDR(32'h0)) u_w0 (
    .clk_i(clk), .reset_i(rst), .req_i(req[0]), .we_i(we), .size_i(size), .signed_i(sgn),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata[0]), .ready_o(ready[0]), .busy_o(busy[0]),
    .err_o(err[0]), .err_addr_o(err_addr[0]));

  dmem_ctrl #(.DEPTH_LOG2(10), .WAIT(1), .BASE_ADDR(32'h0)) u_w1 (
    .clk_i(clk), .reset_i(rst), .req_i(req[1]), .we_i(we), .size_i(size), .signed_i(sgn),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata[1]), .ready_o(ready[1]), .busy_o(busy[1]),
    .err_o(err[1]), .err_addr_o(err_addr[1]));

  dmem_ctrl #(.DEPTH_LOG2(10), .WAIT(3), .BASE_ADDR(32'h0)) u_w3 (
    .clk_i(clk), .reset_i(rst), .req_i(req[2]), .we_i(we), .size_i(size), .signed_i(sgn),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata[2]), .ready_o(ready[2]), .busy_o(busy[2]),
    .err_o(err[2]), .err_addr_o(err_addr[2]));

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] err_addr;
  } exp_t;

  exp_t        exp_q [$];
  int          waits [3] = '{0, 1, 3};
  logic [31:0] last_rd [3];
  logic [31:0] last_ea [3];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a falling edge; returns at a falling edge with the controller idle again.
  task automatic access(input int i, input bit w, input bit [1:0] sz, input bit sg,
                        input bit [31:0] a, input bit [31:0] wd, input bit [31:0] load_rd,
                        input bit flt, input string tag);
    exp_t e;
    int   n;
    bit   got;
    e.tag = tag;
    e.err = flt;
    if (flt)     last_ea[i] = a;
    else if (!w) last_rd[i] = load_rd;
    e.rdata    = last_rd[i];
    e.err_addr = last_ea[i];
    exp_q.push_back(e);
    we = w; size = sz; sgn = sg; addr = a; wdata = wd; req[i] = 1'b1;
    @(posedge clk);
    #1 req[i] = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = ready[i];
    end
    e = exp_q.pop_front();
    if (!got) begin
      check({e.tag, " ready timeout"}, 32'd0, 32'd1);
    end else begin
      check({e.tag, " latency"},  32'(n), 32'(1 + waits[i]));
      check({e.tag, " rdata"},    rdata[i], e.rdata);
      check({e.tag, " err"},      32'(err[i]), 32'(e.err));
      check({e.tag, " err_addr"}, err_addr[i], e.err_addr);
      check({e.tag, " busy"},     32'(busy[i]), 32'd1);
      @(negedge clk);
      check({e.tag, " ready pulse"}, 32'({ready[i], err[i]}), 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0;
      last_rd[i] = 32'd0;
      last_ea[i] = 32'd0;
    end
    we = 1'b0; size = 2'b00; sgn = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset outputs inst%0d", i),
            32'({ready[i], busy[i], err[i]}), 32'd0);
      check($sformatf("reset rdata inst%0d", i), rdata[i], 32'd0);
      check($sformatf("reset err_addr inst%0d", i), err_addr[i], 32'd0);
    end

    // First request issued together with reset release: must be taken on the next edge.
    rst = 1'b0;
    access(1, 1, 2'b10, 0, 32'h10,  32'h1234_5678, 32'd0,          0, "w1 st word");
    access(1, 0, 2'b10, 0, 32'h10,  32'd0,         32'h1234_5678, 0, "w1 ld word");
    access(1, 1, 2'b00, 0, 32'h11,  32'h5A5A_5AAB, 32'd0,          0, "w1 st byte");
    access(1, 0, 2'b10, 0, 32'h10,  32'd0,         32'h1234_AB78, 0, "w1 ld merged");
    access(1, 0, 2'b00, 1, 32'h11,  32'd0,         32'hFFFF_FFAB, 0, "w1 ld byte s");
    access(1, 0, 2'b00, 0, 32'h11,  32'd0,         32'h0000_00AB, 0, "w1 ld byte u");
    access(1, 0, 2'b00, 1, 32'h10,  32'd0,         32'h0000_0078, 0, "w1 ld byte s pos");
    access(1, 1, 2'b01, 0, 32'h12,  32'h7777_BEEF, 32'd0,          0, "w1 st half");
    access(1, 0, 2'b01, 1, 32'h12,  32'd0,         32'hFFFF_BEEF, 0, "w1 ld half s");
    access(1, 0, 2'b01, 0, 32'h10,  32'd0,         32'h0000_AB78, 0, "w1 ld half u");
    access(1, 0, 2'b01, 0, 32'h13,  32'd0,         32'd0,          1, "w1 half misalign");
    access(1, 0, 2'b11, 0, 32'h10,  32'd0,         32'd0,          1, "w1 size rsvd");
    access(1, 1, 2'b10, 0, 32'h12,  32'hCAFE_F00D, 32'd0,          1, "w1 st word misalign");
    access(1, 0, 2'b10, 0, 32'h10,  32'd0,         32'hBEEF_AB78, 0, "w1 ld after faults");
    access(1, 0, 2'b10, 0, 32'h1000, 32'd0,        32'd0,          1, "w1 out of range");
    access(1, 1, 2'b10, 0, 32'hFFC, 32'hA5A5_0FFC, 32'd0,          0, "w1 st top word");
    access(1, 0, 2'b10, 0, 32'hFFC, 32'd0,         32'hA5A5_0FFC, 0, "w1 ld top word");

    access(0, 1, 2'b10, 0, 32'h40,  32'h0BAD_F00D, 32'd0,          0, "w0 st word");
    access(0, 0, 2'b10, 0, 32'h40,  32'd0,         32'h0BAD_F00D, 0, "w0 ld word");
    access(0, 1, 2'b00, 0, 32'h43,  32'h0000_0099, 32'd0,          0, "w0 st byte");
    access(0, 0, 2'b00, 1, 32'h43,  32'd0,         32'hFFFF_FF99, 0, "w0 ld byte s");
    access(0, 0, 2'b10, 0, 32'h40,  32'd0,         32'h99AD_F00D, 0, "w0 ld merged");
    access(0, 0, 2'b01, 1, 32'h41,  32'd0,         32'd0,          1, "w0 half misalign");

    access(2, 1, 2'b10, 0, 32'h20,  32'h1122_3344, 32'd0,          0, "w3 st word");
    access(2, 0, 2'b10, 0, 32'h20,  32'd0,         32'h1122_3344, 0, "w3 ld word");
    access(2, 1, 2'b10, 0, 32'h10,  32'hC0FF_EE00, 32'd0,          0, "w3 st word 2");

    // Back-to-back loads with req held high: one completion every WAIT+2 = 5 cycles.
    begin
      int last_c = -1;
      int lows   = 0;
      int n_rdy  = 0;
      we = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h10; req[2] = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (ready[2]) begin
          if (last_c < 0) check("w3 stream first ready", 32'(c), 32'd4);
          else begin
            check("w3 stream spacing", 32'(c - last_c), 32'd5);
            check("w3 stream busy gap", 32'(lows), 32'd1);
          end
          check("w3 stream rdata", rdata[2], 32'hC0FF_EE00);
          n_rdy++;
          last_c = c;
          lows = 0;
        end else if (!busy[2]) begin
          lows++;
        end
      end
      req[2] = 1'b0;
      check("w3 stream count", 32'(n_rdy), 32'd4);
      @(negedge clk);
      check("w3 stream idle", 32'(busy[2]), 32'd0);
    end

    // Reset in the middle of a store: access is dropped and memory keeps the old word.
    begin
      int seen = 0;
      we = 1'b1; size = 2'b10; sgn = 1'b0; addr = 32'h20; wdata = 32'hDEAD_BEEF; req[2] = 1'b1;
      @(posedge clk);
      #1 req[2] = 1'b0;
      @(negedge clk);
      check("rst mid busy before", 32'(busy[2]), 32'd1);
      rst = 1'b1;
      #1;
      check("rst async busy", 32'(busy[2]), 32'd0);
      check("rst async rdata", rdata[2], 32'd0);
      check("rst async err_addr", err_addr[1], 32'd0);
      repeat (2) begin
        @(negedge clk);
        if (ready[2]) seen++;
      end
      rst = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (ready[2]) seen++;
      end
      check("rst no ready", 32'(seen), 32'd0);
      for (int i = 0; i < 3; i++) begin
        last_rd[i] = 32'd0;
        last_ea[i] = 32'd0;
      end
    end
    access(2, 0, 2'b10, 0, 32'h20,  32'd0, 32'h1122_3344, 0, "w3 ld after rst");
    access(1, 0, 2'b10, 0, 32'h10,  32'd0, 32'hBEEF_AB78, 0, "w1 mem kept");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, meaning: log2 of word count (10 = 1024 words = 4 KB).
REQ-002 Parameter WAIT, default 1, range 0..15, meaning: extra wait-state cycles per access.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, meaning: byte base address, aligned to 4<<DEPTH_LOG2.
REQ-004 One clock; reset is asynchronous and active-high. CLK_I  in  1  clock, all state on rising edge.
REQ-005 RESET_I  in  1  asynchronous active-high reset.
REQ-006 REQ_I  in  1  access request; sampled only in IDLE.
REQ-007 WE_I  in  1  1 = store, 0 = load.
REQ-008 SIZE_I  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SIGNED_I  in  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-010 ADDR_I  in  32  byte address.
REQ-011 WDATA_I  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-012 RDATA_O  out  32  load result, extended to 32 bits.
REQ-013 READY_O  out  1  one-cycle completion pulse.
REQ-014 BUSY_O  out  1  high whenever state is not IDLE.
REQ-015 ERR_O  out  1  one-cycle fault pulse, coincident with READY_O.
REQ-016 ERR_ADDR_O  out  32  address of most recent faulting request.

Function
REQ-017 FSM states IDLE, WAITING, DONE; BUSY_O = (state != IDLE).
REQ-018 In IDLE with REQ_I=1: latch WE_I, SIZE_I, SIGNED_I, ADDR_I, WDATA_I; go to WAITING if WAIT>0, else DONE.
REQ-019 WAITING: counter loads WAIT-1 on accept, decrements each cycle, goes to DONE on the cycle after it reads 0.
REQ-020 DONE lasts exactly one cycle: READY_O=1, then IDLE; REQ_I ignored in WAITING and DONE.
REQ-021 Latency: accept on edge k -> READY_O high in cycle k+1+WAIT; throughput one access per WAIT+2 cycles.
REQ-022 Fault if SIZE=11, or halfword with ADDR[0]=1, or word with ADDR[1:0]!=0, or ADDR[31:DEPTH_LOG2+2] != BASE_ADDR[31:DEPTH_LOG2+2].
REQ-023 Faulting request: same timing as normal; ERR_O=1 with READY_O; ERR_ADDR_O<=latched address; no memory write; RDATA_O unchanged.
REQ-024 Word index = ADDR[DEPTH_LOG2+1:2]; memory is DEPTH words of 32 bits, little-endian byte lanes.
REQ-025 Store commits on the edge leaving DONE: byte writes lane ADDR[1:0], halfword lanes {ADDR[1],0}+1..+0; other lanes preserved.
REQ-026 Load: RDATA_O registered on the edge entering DONE from the selected lane(s), extended per SIGNED_I; valid while READY_O=1 and held until next successful load.
REQ-027 Stores do not modify RDATA_O.
REQ-028 Load after store to same word sees stored data (store committed before next accept).

Reset
REQ-029 RESET_I=1 forces immediately: state IDLE, counter 0, RDATA_O=0, READY_O=0, ERR_O=0, ERR_ADDR_O=0, BUSY_O=0.
REQ-030 Reset mid-access discards the access: no store commits, no READY_O pulse.
REQ-031 Memory array contents are not cleared by reset.
REQ-032 First request is accepted on the first rising edge after RESET_I deasserts with REQ_I=1.

Verification
REQ-033 WAIT=1: store word 0x12345678 @0x10, then load word @0x10 -> READY_O in cycle k+2 of each access, RDATA_O=0x12345678.
REQ-034 Store byte 0xAB @0x11 over 0x12345678, load word -> 0x1234AB78; load byte signed @0x11 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-035 Load halfword @0x13, and word with SIZE=11 -> ERR_O+READY_O pulse, ERR_ADDR_O=0x13, memory and RDATA_O unchanged.
REQ-036 Load @0x0000_1000 (DEPTH_LOG2=10, BASE=0) -> ERR_O=1; store @0x0000_0FFC then load -> correct data, no error.
REQ-037 WAIT=3: REQ_I held high continuously -> READY_O every 5 cycles, BUSY_O low exactly one cycle between accesses.
REQ-038 Assert RESET_I during WAITING of a store of 0xDEADBEEF @0x20 -> no READY_O, later load @0x20 returns prior contents.
